// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: buffers pixels from a drawing source into a small FIFO and
// writes them to a framebuffer port one per cycle; can also fill the whole screen
// with a single colour on request.
// Ports: Clock/Resetn (sync, active-low); VGA_x/VGA_y/VGA_color/VGA_write + ready
// for pixel input; clear/clear_color to request a fill; mem_addr/mem_data/mem_we
// for the framebuffer write port; busy and drop_count for status.
module pixel_fb_writer #(
  parameter int nX          = 8,
  parameter int nY          = 7,
  parameter int COLOR_DEPTH = 3,
  parameter int XMAX        = 160,
  parameter int YMAX        = 120,
  parameter int FDEPTH_LOG2 = 3
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [nX-1:0]          VGA_x,
  input  logic [nY-1:0]          VGA_y,
  input  logic [COLOR_DEPTH-1:0] VGA_color,
  input  logic                   VGA_write,
  output logic                   ready,
  input  logic                   clear,
  input  logic [COLOR_DEPTH-1:0] clear_color,
  output logic [14:0]            mem_addr,
  output logic [COLOR_DEPTH-1:0] mem_data,
  output logic                   mem_we,
  output logic                   busy,
  output logic [7:0]             drop_count
);

  localparam int          DEPTH     = 1 << FDEPTH_LOG2;
  localparam int          EW        = 15 + COLOR_DEPTH;
  localparam logic [14:0] LAST_ADDR = 15'(XMAX * YMAX - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t                   state;
  logic                     clr_pending;
  logic [COLOR_DEPTH-1:0]   clr_color;
  logic [14:0]              clr_addr;

  // FIFO storage and pointers; DEPTH is a power of two so pointers wrap naturally
  logic [EW-1:0]            fifo_mem [DEPTH];
  logic [FDEPTH_LOG2-1:0]   wr_ptr;
  logic [FDEPTH_LOG2-1:0]   rd_ptr;
  logic [FDEPTH_LOG2:0]     count;
  logic                     fifo_empty;
  logic                     fifo_full;

  logic                     in_range;
  logic [14:0]              pix_addr;
  logic                     push;
  logic                     pop;
  logic [EW-1:0]            head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (FDEPTH_LOG2+1)'(DEPTH));

  assign ready = !fifo_full && !clr_pending && (state != CLEAR);

  assign in_range = (int'(VGA_x) < XMAX) && (int'(VGA_y) < YMAX);
  assign pix_addr = 15'(VGA_y) * 15'(XMAX) + 15'(VGA_x);

  // Out-of-range pixels are still accepted (consumed) but never stored
  assign push = VGA_write && ready && in_range;
  assign pop  = (state == DRAIN) && !fifo_empty;
  assign head = fifo_mem[rd_ptr];

  assign busy = !fifo_empty || clr_pending || (state != IDLE) || mem_we;

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pix_addr, VGA_color};
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state       <= IDLE;
      clr_pending <= 1'b0;
      clr_color   <= '0;
      clr_addr    <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      drop_count  <= '0;
    end else begin
      mem_we <= 1'b0;

      if (VGA_write && !ready && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end

      // A clear request only latches when nothing is already pending or running,
      // so this never collides with the pending-clear below (which needs pending=1)
      if (clear && !clr_pending && (state != CLEAR)) begin
        clr_pending <= 1'b1;
        clr_color   <= clear_color;
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= DRAIN;
          end else if (clr_pending) begin
            state       <= CLEAR;
            clr_pending <= 1'b0;
            clr_addr    <= '0;
          end
        end
        DRAIN: begin
          if (!fifo_empty) begin
            mem_we   <= 1'b1;
            mem_addr <= head[EW-1:COLOR_DEPTH];
            mem_data <= head[COLOR_DEPTH-1:0];
          end else if (clr_pending) begin
            state       <= CLEAR;
            clr_pending <= 1'b0;
            clr_addr    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          mem_we   <= 1'b1;
          mem_addr <= clr_addr;
          mem_data <= clr_color;
          if (clr_addr == LAST_ADDR) begin
            state <= IDLE;
          end else begin
            clr_addr <= clr_addr + 15'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
